lib_arb_mux_rr: RTL
===================

Name: lib_arb_mux_rr

Overview:
Registered N-to-1 stream multiplexer for the shared datapath library. It arbitrates round-robin among PORTS_NUMBER valid/ready input channels and selects data with a one-hot AND-OR mux. An optional packet-lock mode holds the grant from the first beat of a packet through its last beat. It sits wherever several encoder/decoder lanes share one downstream consumer.

Parameters:
PORTS_NUMBER, 4, number of input channels (>=2)
WIDTH, 8, data width per channel
PKT_MODE, 1, 1 = grant locked from first beat to s_last beat; 0 = re-arbitrate every beat
ID_W, $clog2(PORTS_NUMBER), width of m_id (derived; not overridden)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
s_valid  input  PORTS_NUMBER  per-channel valid
s_data  input  [WIDTH-1:0] x PORTS_NUMBER (unpacked array)  per-channel data
s_last  input  PORTS_NUMBER  per-channel end-of-packet flag
s_ready  output  PORTS_NUMBER  per-channel ready; at most one bit high
m_valid  output  1  output valid (registered)
m_data  output  WIDTH  output data (registered)
m_last  output  1  output last (registered)
m_id  output  ID_W  index of the channel that sourced the beat (registered)
m_ready  input  1  downstream ready

Behaviour:
- Reset (async, rst_n=0): m_valid=0, m_data=0, m_last=0, m_id=0, state=IDLE, rr pointer=PORTS_NUMBER-1, so port 0 has highest priority on the first arbitration.
- Output stage: single register. Define load = !m_valid || m_ready. s_ready = grant & {PORTS_NUMBER{load}}.
- Transfer: an input beat transfers when s_valid[i] && s_ready[i]. It appears on m_* the next cycle. Latency is 1 cycle. Full throughput is 1 beat/cycle when m_ready is held high.
- When load=1 and no input transfers, m_valid clears next cycle. When m_valid && !m_ready, all m_* hold and all s_ready are 0.
- Grant (combinational, one-hot or zero):
  - IDLE: the first asserted s_valid found scanning from pointer+1 upward, wrapping modulo PORTS_NUMBER. Grant is zero if no s_valid is asserted.
  - LOCKED: grant = locked port, regardless of its s_valid.
- State machine (PKT_MODE=1):
  - IDLE -> LOCKED: a beat transfers with s_last=0. The locked index is stored.
  - IDLE stays IDLE: the transferred beat has s_last=1 (single-beat packet).
  - LOCKED -> IDLE: the locked port's beat with s_last=1 transfers.
  - While LOCKED, a locked port that drops s_valid mid-packet stalls the output. Other ports are not served.
- PKT_MODE=0: the FSM is always IDLE and s_last is passed through only.
- Pointer: updated to the granted index on every transfer made from IDLE. It is unchanged while LOCKED.
- Simultaneous valid: round-robin order is strict. A port that has just been served goes to lowest priority.
- Data path: m_data is loaded from the one-hot AND-OR of s_data with the grant. m_id is loaded with the encoded grant. m_last is loaded from s_last of the granted port.
- Mid-operation reset: takes effect immediately. In-flight output and lock state are discarded.
- Assertions: $onehot0(s_ready); m_* stable while m_valid && !m_ready.

Decomposition:
- Shared package lib_pkg holds:
  - typedef arb_state_e {ARB_IDLE, ARB_LOCKED}
  - function onehot2bin(), used for m_id
  - function rr_next()
- One sub-module: lib_rr_arbiter, parameterized by PORTS_NUMBER.
  - Inputs: req, pointer.
  - Outputs: one-hot gnt and encoded index.
  - Purely combinational, with a double-width masked priority scan.
- Top level owns the FSM, pointer, lock register, output register and AND-OR mux.

Test Plan:
- Reset then single port: s_valid=4'b0100, s_data[2]=8'hA5, s_last=1, m_ready=1 -> s_ready=4'b0100; next cycle m_valid=1, m_data=8'hA5, m_id=2, m_last=1.
- All ports valid continuously, single-beat packets, m_ready=1 -> m_id sequence 0,1,2,3,0,1 with one beat per cycle and no bubbles.
- PKT_MODE=1: port 1 sends a 3-beat packet (last on beat 3) while port 3 is valid throughout -> m_id=1,1,1 then 3. Port 3 s_ready stays 0 during the packet.
- Backpressure: m_ready=0 for 3 cycles with m_valid=1, m_data=8'h3C -> m_* hold 8'h3C, all s_ready=0; the beat is released on the first cycle m_ready=1.
- Lock stall: port 0 drops s_valid after beat 1 of 2 while port 2 is valid -> m_valid=0 next cycle, port 2 is not granted until port 0 completes its last beat.
- Async reset mid-packet: assert rst_n=0 between clk edges while LOCKED -> m_valid=0 immediately. After release, port 0 is arbitrated first.

Source files
------------

// File: rtl/lib_pkg.sv
// Shared datapath library package: arbiter state encoding and small index helpers
// used by the round-robin stream multiplexer.
package lib_pkg;

   typedef enum logic [0:0] {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_e;

   // Binary index of the set bit of a one-hot vector (zero for an all-zero vector).
   function automatic logic [4:0] onehot2bin(input logic [31:0] oh);
      logic [4:0] bin;
      bin = 5'd0;
      for (int i = 0; i < 32; i++) begin
         if (oh[i]) begin
            bin = bin | 5'(i);
         end
      end
      return bin;
   endfunction

   // Index following ptr in a ring of n entries.
   function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
      return ((ptr + 32'd1) >= n) ? 32'd0 : (ptr + 32'd1);
   endfunction

endpackage

// File: rtl/lib_arb_mux_rr_chk.sv
// Protocol checker for lib_arb_mux_rr: single-grant ready and output hold under backpressure.
module lib_arb_mux_rr_chk #(
   parameter int PORTS_NUMBER = 4,
   parameter int WIDTH        = 8,
   parameter int ID_W         = $clog2(PORTS_NUMBER)
) (
   input logic                    clk,
   input logic                    rst_n,
   input logic [PORTS_NUMBER-1:0] s_ready,
   input logic                    m_valid,
   input logic                    m_ready,
   input logic [WIDTH-1:0]        m_data,
   input logic                    m_last,
   input logic [ID_W-1:0]         m_id
);

   a_ready_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(s_ready));

   a_hold_on_stall: assert property (@(posedge clk) disable iff (!rst_n)
      (m_valid && !m_ready) |=> ($stable(m_valid) && $stable(m_data) &&
                                 $stable(m_last) && $stable(m_id)));

endmodule

// File: rtl/lib_rr_arbiter.sv
// Combinational round-robin arbiter: the first request at or after pointer+1,
// found by scanning a doubled request vector so the wrap needs no special case.
module lib_rr_arbiter
   import lib_pkg::*;
#(
   parameter int PORTS_NUMBER = 4,
   parameter int ID_W         = $clog2(PORTS_NUMBER)
) (
   input  logic [PORTS_NUMBER-1:0] req,
   input  logic [ID_W-1:0]         pointer,
   output logic [PORTS_NUMBER-1:0] gnt,
   output logic [ID_W-1:0]         idx
);

   logic [2*PORTS_NUMBER-1:0] req_dbl_s;
   int unsigned               start_s;
   logic                      found_s;

   assign req_dbl_s = {req, req};
   assign start_s   = rr_next(32'(pointer), 32'(PORTS_NUMBER));

   // Masked priority scan over the doubled vector; bits below start are ignored.
   always_comb begin
      gnt     = '0;
      idx     = '0;
      found_s = 1'b0;
      for (int j = 0; j < 2*PORTS_NUMBER; j++) begin
         if (!found_s && (j >= int'(start_s)) && req_dbl_s[j]) begin
            found_s                = 1'b1;
            gnt[j % PORTS_NUMBER]  = 1'b1;
            idx                    = ID_W'(j % PORTS_NUMBER);
         end else begin
            found_s = found_s;
         end
      end
   end

endmodule

// File: rtl/lib_arb_mux_rr.sv
// Registered N-to-1 round-robin stream multiplexer with optional packet lock:
// once a multi-beat packet starts, its port keeps the grant until its last beat.
module lib_arb_mux_rr
   import lib_pkg::*;
#(
   parameter int PORTS_NUMBER = 4,
   parameter int WIDTH        = 8,
   parameter int PKT_MODE     = 1,
   parameter int ID_W         = $clog2(PORTS_NUMBER)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [PORTS_NUMBER-1:0] s_valid,
   input  logic [WIDTH-1:0]        s_data [PORTS_NUMBER],
   input  logic [PORTS_NUMBER-1:0] s_last,
   output logic [PORTS_NUMBER-1:0] s_ready,
   output logic                    m_valid,
   output logic [WIDTH-1:0]        m_data,
   output logic                    m_last,
   output logic [ID_W-1:0]         m_id,
   input  logic                    m_ready
);

   arb_state_e                state_r;
   arb_state_e                state_nx_s;
   logic [ID_W-1:0]           ptr_r;
   logic [ID_W-1:0]           lock_idx_r;
   logic [ID_W-1:0]           arb_idx_s;
   logic [PORTS_NUMBER-1:0]   arb_gnt_s;
   logic [PORTS_NUMBER-1:0]   grant_s;
   logic                      load_s;
   logic                      xfer_s;
   logic                      last_s;
   logic [WIDTH-1:0]          data_s;

   lib_rr_arbiter #(
      .PORTS_NUMBER (PORTS_NUMBER),
      .ID_W         (ID_W)
   ) u_arb (
      .req     (s_valid),
      .pointer (ptr_r),
      .gnt     (arb_gnt_s),
      .idx     (arb_idx_s)
   );

   assign load_s  = !m_valid || m_ready;
   assign s_ready = grant_s & {PORTS_NUMBER{load_s}};
   assign xfer_s  = |(s_valid & s_ready);

   // Locked port owns the grant even while its valid is low, stalling the output.
   always_comb begin
      grant_s = '0;
      if (state_r == ARB_LOCKED) begin
         grant_s[lock_idx_r] = 1'b1;
      end else begin
         grant_s = arb_gnt_s;
      end
   end

   // One-hot AND-OR selection of data and last.
   always_comb begin
      data_s = '0;
      last_s = 1'b0;
      for (int i = 0; i < PORTS_NUMBER; i++) begin
         data_s = data_s | (s_data[i] & {WIDTH{grant_s[i]}});
         last_s = last_s | (s_last[i] & grant_s[i]);
      end
   end

   // Packet lock next-state decode.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ARB_IDLE: begin
            if ((PKT_MODE != 32'sd0) && xfer_s && !last_s) begin
               state_nx_s = ARB_LOCKED;
            end else begin
               state_nx_s = ARB_IDLE;
            end
         end
         ARB_LOCKED: begin
            if (xfer_s && last_s) begin
               state_nx_s = ARB_IDLE;
            end else begin
               state_nx_s = ARB_LOCKED;
            end
         end
         default: state_nx_s = ARB_IDLE;
      endcase
   end

   // FSM, round-robin pointer and locked index; pointer only moves on unlocked transfers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ARB_IDLE;
         ptr_r      <= ID_W'(PORTS_NUMBER - 1);
         lock_idx_r <= '0;
      end else begin
         state_r <= state_nx_s;
         if (xfer_s && (state_r == ARB_IDLE)) begin
            ptr_r      <= arb_idx_s;
            lock_idx_r <= arb_idx_s;
         end
      end
   end

   // Output register stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid <= 1'b0;
         m_data  <= '0;
         m_last  <= 1'b0;
         m_id    <= '0;
      end else if (load_s) begin
         m_valid <= xfer_s;
         if (xfer_s) begin
            m_data <= data_s;
            m_last <= last_s;
            m_id   <= ID_W'(onehot2bin(32'(grant_s)));
         end
      end
   end

endmodule
